// File: rtl/ppu_fb_pkg.sv
// Shared types and pixel helpers for the PPU framebuffer writer.
// Optional ordered dither is compiled in with PPU_FB_DITHER_EN.
package ppu_fb_pkg;

    localparam int FB_WIDTH  = 256;
    localparam int FB_HEIGHT = 240;

    // 2x2 ordered dither matrix, indexed by {y[0], x[0]}
    localparam logic [1:0] DITHER_M [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

    typedef enum logic {
        S_IDLE,
        S_REQ
    } fb_state_e;

    // addr is carried at full width; the top truncates it to its address width
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  be;
    } fb_word_t;

    function automatic logic [15:0] rgb565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

`ifdef PPU_FB_DITHER_EN
    function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [2:0] d);
        logic [8:0] s;
        s = {1'b0, c} + {6'd0, d};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [23:0] dither(input logic [23:0] rgb, input logic [1:0] d);
        return {sat_add(rgb[23:16], {d, 1'b0}),
                sat_add(rgb[15:8],  {1'b0, d}),
                sat_add(rgb[7:0],   {d, 1'b0})};
    endfunction
`endif

endpackage

// File: rtl/ppu_fb_writer_fifo.sv
// Generic single-clock FIFO with a registered show-ahead head word.
// Memory is an array with registered read; a bypass covers writes into an empty FIFO.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  T              din,
    input  logic          rd,
    output T              head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    T              mem [DEPTH];
    T              head_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [LW-1:0] level_reg;
    logic          do_wr;
    logic          do_rd;

    assign full        = (level_reg == LW'(DEPTH));
    assign empty       = (level_reg == '0);
    assign do_rd       = rd && !empty;
    // a full FIFO still accepts a write when the same cycle frees a slot
    assign do_wr       = wr && (!full || do_rd);
    assign rd_ptr_next = do_rd ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_reg + LW'(do_wr) - LW'(do_rd);
            // head only moves when a new word becomes the oldest entry
            if (do_rd || (do_wr && empty)) begin
                head_reg <= (do_wr && (wr_ptr_reg == rd_ptr_next)) ? din : mem[rd_ptr_next];
            end
        end
    end

    assign head  = head_reg;
    assign level = level_reg;

endmodule

// File: rtl/ppu_fb_writer.sv
// PPU pixel stream to framebuffer writer: RGB565 packing, word FIFO and req/ack master.
// Define PPU_FB_DITHER_EN to enable 2x2 ordered dither ahead of the RGB565 truncation.
module ppu_fb_writer
    import ppu_fb_pkg::*;
#(
    parameter int  WIDTH  = FB_WIDTH,
    parameter int  HEIGHT = FB_HEIGHT,
    parameter int  BASE   = 0,
    parameter int  AW     = 16,
    parameter int  DEPTH  = 8,
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [8:0]    ppu_x,
    input  logic [8:0]    ppu_y,
    input  logic [23:0]   ppu_rgb,
    input  logic          ppu_we,
    output logic          fb_req,
    output logic [AW-1:0] fb_addr,
    output logic [31:0]   fb_data,
    output logic [1:0]    fb_be,
    input  logic          fb_ack,
    output logic          frame_done,
    output logic          overflow,
    output logic [LW-1:0] fifo_level
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(BASE + WIDTH * HEIGHT / 2 - 1);

    fb_state_e     state_reg, state_next;
    logic          pend_valid_reg, pend_valid_next;
    logic [AW-1:0] pend_addr_reg, pend_addr_next;
    logic [15:0]   pend_lo_reg, pend_lo_next;
    logic          overflow_reg;

    logic          accept;
    logic [AW-1:0] word_addr;
    logic [15:0]   pix565;
    logic          push_valid;
    fb_word_t      push_word;
    logic          pop;

    fb_word_t      head;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;

    always_comb begin
        accept    = ppu_we && (int'(ppu_x) < WIDTH) && (int'(ppu_y) < HEIGHT);
        word_addr = AW'(32'(BASE) + ((32'(ppu_y) * 32'(WIDTH) + 32'(ppu_x)) >> 1));
`ifdef PPU_FB_DITHER_EN
        pix565    = rgb565(dither(ppu_rgb, DITHER_M[{ppu_y[0], ppu_x[0]}]));
`else
        pix565    = rgb565(ppu_rgb);
`endif
    end

    // Packing: even pixels park in the pending register, odd pixels complete a word.
    always_comb begin
        push_valid      = 1'b0;
        push_word       = '0;
        pend_valid_next = pend_valid_reg;
        pend_addr_next  = pend_addr_reg;
        pend_lo_next    = pend_lo_reg;
        if (accept) begin
            if (!ppu_x[0]) begin
                if (pend_valid_reg) begin
                    push_valid = 1'b1;
                    push_word  = '{addr: 32'(pend_addr_reg), data: {16'h0, pend_lo_reg}, be: 2'b01};
                end
                pend_valid_next = 1'b1;
                pend_addr_next  = word_addr;
                pend_lo_next    = pix565;
            end else if (pend_valid_reg && (pend_addr_reg == word_addr)) begin
                push_valid      = 1'b1;
                push_word       = '{addr: 32'(word_addr), data: {pix565, pend_lo_reg}, be: 2'b11};
                pend_valid_next = 1'b0;
            end else begin
                push_valid = 1'b1;
                push_word  = '{addr: 32'(word_addr), data: {pix565, 16'h0}, be: 2'b10};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= '0;
            pend_lo_reg    <= '0;
            overflow_reg   <= 1'b0;
            state_reg      <= S_IDLE;
        end else begin
            pend_valid_reg <= pend_valid_next;
            pend_addr_reg  <= pend_addr_next;
            pend_lo_reg    <= pend_lo_next;
            state_reg      <= state_next;
            if (push_valid && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (!empty) state_next = S_REQ;
            // leave REQ when the word being acked is the last one held
            S_REQ:  if (fb_ack) state_next = (level > LW'(1)) ? S_REQ : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign fb_req = (state_reg == S_REQ);
    assign pop    = fb_req && fb_ack;

    sync_fifo #(
        .T     (fb_word_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push_valid),
        .din   (push_word),
        .rd    (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign fb_addr    = head.addr[AW-1:0];
    assign fb_data    = head.data;
    assign fb_be      = head.be;
    assign frame_done = pop && (head.addr == 32'(LAST_ADDR));
    assign overflow   = overflow_reg;
    assign fifo_level = level;

endmodule
